path_playback_ctrl: RTL and testbench
=====================================

Name: path_playback_ctrl

Overview:
Sequences replay of a solved maze path. After the solver reports success, the block captures the path length. On a `run` request it reads the stored moves from the path memory one per slot and drives `Move` at a fixed cadence. It sits between the solver core (path stack/RAM, Done/Fail) and the top-level `Move` output.

Parameters:
ADDR_W, 8, path memory address width; maximum path length is 2^ADDR_W moves.
MOVE_PERIOD, 2, clock cycles each move is presented; legal range 2..255.

Ports:
clk  input  1  system clock, rising edge.
rst  input  1  asynchronous active-low reset.
solved  input  1  solver success; a high level for at least 1 cycle arms the block.
fail  input  1  solver failure; a high level disarms the block or aborts playback.
path_len  input  ADDR_W+1  number of stored moves; sampled on the first cycle `solved` is high.
run  input  1  playback request; rising-edge detected internally.
rd_en  output  1  path memory read strobe.
rd_addr  output  ADDR_W  path memory read address.
rd_data  input  2  move word; valid exactly 1 cycle after `rd_en`.
Move  output  2  current move: 00 up, 01 right, 10 down, 11 left.
move_valid  output  1  1-cycle pulse when `Move` takes a new value.
busy  output  1  high in the FETCH/SHOW states.
play_done  output  1  1-cycle pulse after the last move's slot ends.

Behaviour:
- Reset (`rst`=0, async): state IDLE; all outputs 0; captured length 0; run edge detector cleared.
- Run edge detect: registered `run_q`; start request = `run & ~run_q`. `run` held high produces one request only.
- IDLE:
  - `solved`=1 -> ARMED; capture `path_len` into `len_r`.
  - `fail` has priority over `solved` in the same cycle; both high -> stay IDLE.
- ARMED:
  - `fail`=1 -> IDLE.
  - `solved` re-asserted -> recapture `len_r`.
  - Start request with `len_r`=0 -> `play_done` pulse next cycle, stay ARMED, no `rd_en`.
  - Start request with `len_r`>0 -> FETCH; index `idx` <= 0.
- FETCH (1 cycle): `rd_en`=1, `rd_addr`=`idx`; -> SHOW.
- SHOW:
  - Entry cycle: `Move` <= `rd_data`, `move_valid`=1, slot counter <= 1.
  - Counter increments every cycle.
  - At counter = MOVE_PERIOD-1, if `idx`+1 < `len_r`: `idx`++, -> FETCH. Consecutive `move_valid` pulses are therefore exactly MOVE_PERIOD cycles apart.
  - Otherwise, at counter = MOVE_PERIOD-1: -> ARMED and `play_done` pulses on the following cycle. Replay on a later start request is allowed.
- Latency: start request sampled at cycle N -> `rd_en` at N+1 -> first `move_valid` at N+2.
- `Move` holds its last value after playback and in ARMED; it is cleared only by reset.
- During FETCH/SHOW:
  - start requests and `solved` are ignored.
  - `fail`=1 aborts to IDLE next cycle: no `play_done`, `Move` retains its value, `busy` drops.
- `len_r` = 2^ADDR_W is legal; `idx` wraps naturally only past the final move, which is never fetched.
- `rd_addr` holds its last value when `rd_en`=0.

Optional Feature:
REVERSE_PLAY_EN:
- Defined: adds input port `rev` (1 bit), sampled with the start request.
  - `rev`=1 -> addresses are fetched `len_r`-1 down to 0.
  - Each move is inverted before output (`Move` = `rd_data` ^ 2'b10), retracing the path from goal to start.
  - `rev`=0 behaves exactly as forward playback.
- Undefined: no `rev` port; forward playback only.

Test Plan:
- Reset mid-playback: assert `rst`=0 during SHOW -> all outputs 0 immediately (async); after release the block stays IDLE and `run` is ignored until `solved`.
- Basic replay: memory = {01,01,10,11}, `path_len`=4, `solved` pulse, `run` pulse -> `rd_en` at addresses 0..3; `Move` = 01,01,10,11 with `move_valid` every 2 cycles; `play_done` 1 cycle after the 4th slot ends; then a second `run` replays identically.
- Period/latency: MOVE_PERIOD=5, `path_len`=3 -> first `move_valid` 2 cycles after the `run` edge, pulses 5 cycles apart; `run` held high for 50 cycles triggers only one playback.
- Boundaries:
  - `path_len`=0 -> `run` yields `play_done` with no `rd_en` and no `move_valid`.
  - `path_len`=256 (ADDR_W=8) -> 256 moves, last `rd_addr`=255.
- Fail handling:
  - `fail` during SHOW of move 2 -> `busy` falls next cycle, no `play_done`, `Move` holds.
  - `fail` and `solved` in the same cycle from IDLE -> block stays IDLE.
- REVERSE_PLAY_EN: memory {00,01,01}, `rev`=1 -> addresses 2,1,0; `Move` = 11,11,10.

Source files
------------

// File: rtl/path_playback_ctrl.sv
// Replays a solved maze path from the path memory, one move per MOVE_PERIOD-cycle slot.
// Optional reverse replay (goal -> start, inverted moves) is enabled by defining REVERSE_PLAY_EN.
module path_playback_ctrl #(
  parameter int ADDR_W      = 8,
  parameter int MOVE_PERIOD = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              solved,
  input  logic              fail,
  input  logic [ADDR_W:0]   path_len,
  input  logic              run,
`ifdef REVERSE_PLAY_EN
  input  logic              rev,
`endif
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [1:0]        rd_data,
  output logic [1:0]        Move,
  output logic              move_valid,
  output logic              busy,
  output logic              play_done
);

  typedef enum logic [1:0] {IDLE, ARMED, FETCH, SHOW} state_t;

  localparam logic [7:0]        LAST  = 8'(MOVE_PERIOD - 1);
  localparam logic [ADDR_W:0]   ONE_L = 1;
  localparam logic [ADDR_W-1:0] ONE_A = 1;

  state_t            state;
  logic              run_q, done_pend, rev_r, rev_in;
  logic [ADDR_W:0]   len_r;
  logic [ADDR_W-1:0] idx, idx_nxt, idx_first;
  logic [7:0]        cnt, cnt_nxt;
  logic [1:0]        mv_xor;
  logic              start, more;

`ifdef REVERSE_PLAY_EN
  assign rev_in = rev;
`else
  assign rev_in = 1'b0;
`endif

  assign start     = run & ~run_q;
  assign idx_first = rev_in ? (len_r[ADDR_W-1:0] - ONE_A) : '0;
  assign idx_nxt   = rev_r ? (idx - ONE_A) : (idx + ONE_A);
  // idx never advances past the final move, so a full 2^ADDR_W path never wraps a fetch
  assign more      = rev_r ? (idx != '0) : (({1'b0, idx} + ONE_L) < len_r);
  assign mv_xor    = rev_r ? 2'b10 : 2'b00;
  // cnt == 0 marks the SHOW entry cycle, when rd_data carries the fetched move
  assign cnt_nxt   = (cnt == 8'd0) ? 8'd1 : cnt + 8'd1;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      run_q      <= 1'b0;
      done_pend  <= 1'b0;
      rev_r      <= 1'b0;
      len_r      <= '0;
      idx        <= '0;
      cnt        <= '0;
      rd_en      <= 1'b0;
      rd_addr    <= '0;
      Move       <= 2'b00;
      move_valid <= 1'b0;
      busy       <= 1'b0;
      play_done  <= 1'b0;
    end else begin
      run_q      <= run;
      rd_en      <= 1'b0;
      move_valid <= 1'b0;
      done_pend  <= 1'b0;
      play_done  <= done_pend;
      case (state)
        IDLE: begin
          if (solved && !fail) begin
            state <= ARMED;
            len_r <= path_len;
          end
        end
        ARMED: begin
          if (fail) begin
            state <= IDLE;
          end else begin
            if (solved) len_r <= path_len;
            if (start) begin
              if (len_r == '0) begin
                done_pend <= 1'b1;
              end else begin
                state   <= FETCH;
                busy    <= 1'b1;
                rd_en   <= 1'b1;
                idx     <= idx_first;
                rd_addr <= idx_first;
                rev_r   <= rev_in;
              end
            end
          end
        end
        FETCH: begin
          if (fail) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else begin
            state <= SHOW;
            cnt   <= '0;
          end
        end
        SHOW: begin
          if (fail) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else begin
            cnt <= cnt_nxt;
            if (cnt == 8'd0) begin
              Move       <= rd_data ^ mv_xor;
              move_valid <= 1'b1;
            end
            // next fetch overlaps the current slot so moves land exactly MOVE_PERIOD apart
            if (more && cnt_nxt == LAST) begin
              state   <= FETCH;
              rd_en   <= 1'b1;
              idx     <= idx_nxt;
              rd_addr <= idx_nxt;
            end else if (!more && cnt == LAST) begin
              state     <= ARMED;
              busy      <= 1'b0;
              done_pend <= 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_path_playback_ctrl.sv
// Directed bench for path_playback_ctrl: one instance at MOVE_PERIOD=2, one at MOVE_PERIOD=5,
// each with its own synchronous path memory port.
module tb_path_playback_ctrl;
  localparam int AW = 8;

  logic clk = 1'b0, rst = 1'b1, solved = 1'b0, fail = 1'b0, run = 1'b0;
  logic [AW:0] path_len = '0;
`ifdef REVERSE_PLAY_EN
  logic rev = 1'b0;
`endif
  logic          rd_en2, rd_en5, mv2, mv5, busy2, busy5, pd2, pd5;
  logic [AW-1:0] rd_addr2, rd_addr5;
  logic [1:0]    rd_data2 = 2'b00, rd_data5 = 2'b00, move2, move5;
  logic [1:0]    mem [256];

  int ncmp = 0, nfail = 0, cyc = 0, R = 0;
  int ra2[$], rc2[$], mq2[$], mc2[$], pc2[$];
  int ra5[$], mq5[$], mc5[$], pc5[$];

  path_playback_ctrl #(.ADDR_W(AW), .MOVE_PERIOD(2)) u2 (
    .clk(clk), .rst(rst), .solved(solved), .fail(fail), .path_len(path_len), .run(run),
`ifdef REVERSE_PLAY_EN
    .rev(rev),
`endif
    .rd_en(rd_en2), .rd_addr(rd_addr2), .rd_data(rd_data2), .Move(move2),
    .move_valid(mv2), .busy(busy2), .play_done(pd2));

  path_playback_ctrl #(.ADDR_W(AW), .MOVE_PERIOD(5)) u5 (
    .clk(clk), .rst(rst), .solved(solved), .fail(fail), .path_len(path_len), .run(run),
`ifdef REVERSE_PLAY_EN
    .rev(1'b0),
`endif
    .rd_en(rd_en5), .rd_addr(rd_addr5), .rd_data(rd_data5), .Move(move5),
    .move_valid(mv5), .busy(busy5), .play_done(pd5));

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rd_en2) rd_data2 <= mem[rd_addr2];
    if (rd_en5) rd_data5 <= mem[rd_addr5];
  end

  always @(negedge clk) begin
    if (rd_en2) begin ra2.push_back(int'(rd_addr2)); rc2.push_back(cyc); end
    if (mv2)    begin mq2.push_back(int'(move2));    mc2.push_back(cyc); end
    if (pd2)    pc2.push_back(cyc);
    if (rd_en5) ra5.push_back(int'(rd_addr5));
    if (mv5)    begin mq5.push_back(int'(move5));    mc5.push_back(cyc); end
    if (pd5)    pc5.push_back(cyc);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic clr();
    ra2.delete(); rc2.delete(); mq2.delete(); mc2.delete(); pc2.delete();
    ra5.delete(); mq5.delete(); mc5.delete(); pc5.delete();
  endtask

  task automatic pulse_solved(input int len);
    @(negedge clk);
    path_len = (AW+1)'(len);
    solved   = 1'b1;
    @(negedge clk);
    solved   = 1'b0;
  endtask

  // R = cycle index right after the edge that samples the run rise
  task automatic do_run();
    run = 1'b1;
    @(negedge clk);
    R   = cyc;
    run = 1'b0;
  endtask

  function automatic int qget(input int q[$], input int i);
    return (i < q.size()) ? q[i] : -1;
  endfunction

  task automatic chk_basic(input string tag);
    int exp_mv[4] = '{1, 1, 2, 3};
    chk({tag, "_nrd"}, ra2.size(), 4);
    for (int i = 0; i < 4; i++) begin
      chk({tag, "_addr"}, qget(ra2, i), i);
      chk({tag, "_rdcyc"}, qget(rc2, i), R + 2*i);
      chk({tag, "_move"}, qget(mq2, i), exp_mv[i]);
      chk({tag, "_mvcyc"}, qget(mc2, i), R + 2 + 2*i);
    end
    chk({tag, "_npd"}, pc2.size(), 1);
    chk({tag, "_pdcyc"}, qget(pc2, 0), R + 10);
    chk({tag, "_busy"}, busy2, 0);
  endtask

  initial begin
    int bad;
    for (int i = 0; i < 256; i++) mem[i] = 2'b00;

    // async reset at power-up
    #1 rst = 1'b0;
    #10;
    chk("rst_move", move2, 0);
    chk("rst_mv", mv2, 0);
    chk("rst_busy", busy2, 0);
    chk("rst_pd", pd2, 0);
    chk("rst_rden", rd_en2, 0);
    chk("rst_addr", rd_addr2, 0);
    @(negedge clk) rst = 1'b1;
    step(2);

    // fail and solved together from IDLE: stays IDLE, run ignored
    @(negedge clk);
    path_len = 9'd4; solved = 1'b1; fail = 1'b1;
    @(negedge clk);
    solved = 1'b0; fail = 1'b0;
    clr(); do_run(); step(8);
    chk("fs_nrd", ra2.size(), 0);
    chk("fs_npd", pc2.size(), 0);
    chk("fs_busy", busy2, 0);

    // basic replay, then identical second replay
    mem[0] = 2'b01; mem[1] = 2'b01; mem[2] = 2'b10; mem[3] = 2'b11;
    pulse_solved(4);
    clr(); do_run(); step(24);
    chk_basic("basic");
    clr(); do_run(); step(24);
    chk_basic("replay");

    // period 5 with run held high for 50 cycles: one playback only
    mem[0] = 2'b10; mem[1] = 2'b11; mem[2] = 2'b00;
    pulse_solved(3);
    clr();
    run = 1'b1;
    @(negedge clk);
    R = cyc;
    step(49);
    run = 1'b0;
    step(5);
    chk("p5_nrd", ra5.size(), 3);
    chk("p5_mv0", qget(mc5, 0), R + 2);
    chk("p5_mv1", qget(mc5, 1), R + 7);
    chk("p5_mv2", qget(mc5, 2), R + 12);
    chk("p5_move0", qget(mq5, 0), 2);
    chk("p5_move1", qget(mq5, 1), 3);
    chk("p5_move2", qget(mq5, 2), 0);
    chk("p5_npd", pc5.size(), 1);
    chk("p5_pdcyc", qget(pc5, 0), R + 17);
    chk("p5_busy", busy5, 0);
    chk("p2_held_npd", pc2.size(), 1);

    // zero-length path
    pulse_solved(0);
    clr(); do_run(); step(6);
    chk("l0_nrd", ra2.size(), 0);
    chk("l0_nmv", mq2.size(), 0);
    chk("l0_npd", pc2.size(), 1);
    chk("l0_pdcyc", qget(pc2, 0), R + 1);

    // full-size path of 256 moves
    for (int i = 0; i < 256; i++) mem[i] = 2'((i * 3) + (i / 7));
    pulse_solved(256);
    clr(); do_run(); step(1300);
    chk("l256_nrd", ra2.size(), 256);
    chk("l256_last", qget(ra2, 255), 255);
    chk("l256_nmv", mq2.size(), 256);
    bad = 0;
    for (int i = 0; i < 256; i++)
      if (qget(mq2, i) != int'(mem[i])) bad++;
    chk("l256_seq", bad, 0);
    chk("l256_pdcyc", qget(pc2, 0), R + 514);

    // fail while move 2 is being shown
    mem[0] = 2'b01; mem[1] = 2'b01; mem[2] = 2'b10; mem[3] = 2'b11;
    pulse_solved(4);
    clr(); do_run(); step(4);
    chk("fl_busy_pre", busy2, 1);
    fail = 1'b1;
    @(negedge clk);
    fail = 1'b0;
    chk("fl_busy_post", busy2, 0);
    step(10);
    chk("fl_npd", pc2.size(), 0);
    chk("fl_nmv", mq2.size(), 2);
    chk("fl_hold", move2, 2'b01);
    clr(); do_run(); step(6);
    chk("fl_idle_nrd", ra2.size(), 0);

    // reset in the middle of playback
    pulse_solved(4);
    clr(); do_run(); step(3);
    chk("mr_busy_pre", busy2, 1);
    #2 rst = 1'b0;
    #1;
    chk("mr_busy", busy2, 0);
    chk("mr_move", move2, 0);
    chk("mr_addr", rd_addr2, 0);
    @(negedge clk) rst = 1'b1;
    clr(); do_run(); step(6);
    chk("mr_idle_nrd", ra2.size(), 0);
    chk("mr_idle_busy", busy2, 0);

`ifdef REVERSE_PLAY_EN
    // reverse playback retraces with inverted moves
    mem[0] = 2'b00; mem[1] = 2'b01; mem[2] = 2'b01;
    pulse_solved(3);
    rev = 1'b1;
    clr(); do_run();
    rev = 1'b0;
    step(12);
    chk("rv_a0", qget(ra2, 0), 2);
    chk("rv_a1", qget(ra2, 1), 1);
    chk("rv_a2", qget(ra2, 2), 0);
    chk("rv_m0", qget(mq2, 0), 3);
    chk("rv_m1", qget(mq2, 1), 3);
    chk("rv_m2", qget(mq2, 2), 2);
    chk("rv_npd", pc2.size(), 1);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "timeout");
  end

endmodule
